// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared controller codes, fetch FSM states and pipeline constants
package if_stage_pkg;
   typedef enum logic [1:0] {
      CTRL_STATE_Default = 2'b00,
      CTRL_STATE_Bubble  = 2'b01,
      CTRL_STATE_Stalled = 2'b10
   } ctrl_e;
   typedef enum logic [1:0] {IF_IDLE, IF_FETCH, IF_HOLD, IF_DRAIN} if_state_e;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [63:0] INVALID_PC = 64'h0;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: single-outstanding instruction-memory request/valid bus
interface if_stage_if #(
   parameter int ADDR_W = 64,
   parameter int INST_W = 32
);
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              valid;
   logic [INST_W-1:0] rdata;
   modport master (output req, addr, input valid, rdata);
   modport slave (input req, addr, output valid, rdata);
endinterface

// File: rtl/if_pc_gen.sv
// if_pc_gen: next fetch PC, redirect over sequential advance over hold
module if_pc_gen #(
   parameter int ADDR_W = 64
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              advance,
   output logic [ADDR_W-1:0] next_pc
);
   always_comb next_pc = redirect ? redirect_pc & ~ADDR_W'(3) : advance ? pc + ADDR_W'(4) : pc;
endmodule

// File: rtl/if_stage.sv
// if_stage: fetch PC owner, single-outstanding imem fetch, presents {pc, inst} to IF/ID
module if_stage
   import if_stage_pkg::*;
#(
   parameter int              ADDR_W   = 64,
   parameter int              INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        ctrl_signal_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   if_stage_if.master        imem,
   output logic              stall_req_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic [INST_W-1:0] if_inst_o
);
   if_state_e         state, state_nx;
   logic [ADDR_W-1:0] pc, pc_nx, drain_addr, drain_addr_nx;
   logic [INST_W-1:0] held, held_nx, word;
   logic              busy, avail, consume;

   if_pc_gen #(.ADDR_W(ADDR_W)) u_pc_gen (
      .pc(pc),
      .redirect(redirect_i),
      .redirect_pc(redirect_pc_i),
      .advance(consume),
      .next_pc(pc_nx)
   );

   assign busy = state == IF_FETCH || state == IF_DRAIN;
   assign avail = (state == IF_FETCH && imem.valid) || state == IF_HOLD;
   assign word = state == IF_HOLD ? held : imem.rdata;
   assign consume = avail && ctrl_signal_i == CTRL_STATE_Default && !redirect_i;

   // DRAIN keeps presenting the abandoned address until its word returns
   assign imem.req = busy;
   assign imem.addr = state == IF_DRAIN ? drain_addr : pc;
   assign stall_req_o = !avail;
   assign pc_o = avail ? pc : ADDR_W'(INVALID_PC);
   assign if_inst_o = avail ? word : INST_W'(NOP);

   always_comb begin
      state_nx = state;
      held_nx = held;
      drain_addr_nx = drain_addr;
      if (redirect_i) begin
         state_nx = busy && !imem.valid ? IF_DRAIN : IF_FETCH;
         held_nx = INST_W'(NOP);
         drain_addr_nx = imem.addr;
      end else begin
         state_nx = state == IF_IDLE ? IF_FETCH :
                    state == IF_DRAIN ? (imem.valid ? IF_FETCH : IF_DRAIN) :
                    consume ? IF_FETCH : avail ? IF_HOLD : state;
         held_nx = state == IF_FETCH && avail && !consume ? imem.rdata : held;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IF_IDLE;
         pc <= RESET_PC;
         held <= INST_W'(NOP);
         drain_addr <= RESET_PC;
      end else begin
         state <= state_nx;
         pc <= pc_nx;
         held <= held_nx;
         drain_addr <= drain_addr_nx;
      end
   end
endmodule
